// File: rtl/temp_seg_encoder.sv
// ---------------------------------------------------------------------------
// temp_seg_encoder
//   Turns a signed two's-complement temperature into four active-low
//   7-segment digit codes for the scanned display driver. The binary value is
//   converted to BCD by an iterative double-dabble engine, then formatted with
//   optional leading-zero blanking, a floating minus sign and an overflow
//   pattern of four minus signs.
//
// Ports
//   clk_i     in   1     system clock, rising edge
//   rst_i     in   1     asynchronous active-high reset
//   load_i    in   1     one-cycle request to convert value_i
//   value_i   in   IN_W  signed temperature, sampled with load_i
//   busy_o    out  1     conversion in progress
//   done_o    out  1     one-cycle pulse when number_o has just been updated
//   number_o  out  28    {dig3,dig2,dig1,dig0}, 7 bits each, bit0=a .. bit6=g
//
// Handshake: a request is the cycle in which load_i is high at a rising edge.
// Requests arriving while a conversion is under way are kept in a one-entry
// pending register (the newest overwrites older ones) and serviced in the
// next IDLE cycle. Every accepted conversion ends with exactly one done_o
// pulse, in the same cycle that number_o takes its new value.
// ---------------------------------------------------------------------------
module temp_seg_encoder #(
  parameter int IN_W = 14,
  parameter bit LZB  = 1'b1
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            load_i,
  input  logic [IN_W-1:0] value_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [27:0]     number_o
);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [4:0] CNT_LAST  = 5'(IN_W);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CONV = 2'd1,
    S_ENC  = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [IN_W-1:0] mag_q, mag_d;
  logic            neg_q, neg_d;
  logic            minov_q, minov_d;
  logic [19:0]     bcd_q, bcd_d;
  logic [4:0]      cnt_q, cnt_d;
  logic            pend_v_q, pend_v_d;
  logic [IN_W-1:0] pend_q, pend_d;
  logic [27:0]     number_q, number_d;
  logic            done_q, done_d;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  // Add-3 correction for the four low BCD digits.
  function automatic logic [15:0] dd_adjust(input logic [15:0] b);
    logic [15:0] r;
    r = b;
    for (int n = 0; n < 4; n++) begin
      if (r[4*n +: 4] >= 4'd5) r[4*n +: 4] = r[4*n +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Source for a new conversion: a pending request always goes first.
  logic [IN_W-1:0] cap_src;
  logic            cap_neg;
  logic [IN_W-1:0] cap_mag;
  logic            cap_minov;
  logic [15:0]     bcd_adj;

  assign cap_src   = pend_v_q ? pend_q : value_i;
  assign cap_neg   = cap_src[IN_W-1];
  assign cap_mag   = cap_neg ? (~cap_src + IN_W'(1)) : cap_src;
  // The most negative code has no positive IN_W-bit twin; flag it outright.
  assign cap_minov = (cap_src == {1'b1, {(IN_W-1){1'b0}}});
  assign bcd_adj   = dd_adjust(bcd_q[15:0]);

  // Digit formatting from the finished BCD value.
  logic [27:0] enc_num;
  logic [3:0]  show;
  logic        seen;
  logic        ovf;

  always_comb begin
    enc_num = {4{SEG_BLANK}};
    show    = 4'b0000;
    seen    = 1'b0;
    ovf     = minov_q || (bcd_q[19:16] != 4'd0) || (neg_q && (bcd_q[15:12] != 4'd0));
    // A digit is shown once any digit at or above it is non-zero; dig0 always.
    for (int i = 3; i >= 0; i--) begin
      seen    = seen | (bcd_q[4*i +: 4] != 4'd0) | (i == 0);
      show[i] = seen | !LZB;
    end
    for (int i = 0; i < 4; i++) begin
      if (show[i]) enc_num[7*i +: 7] = seg7(bcd_q[4*i +: 4]);
    end
    if (neg_q) begin
      if (!LZB) begin
        enc_num[27:21] = SEG_MINUS;
      end else begin
        // Minus sits just left of the most significant shown digit.
        for (int i = 1; i < 4; i++) begin
          if (!show[i] && show[i-1]) enc_num[7*i +: 7] = SEG_MINUS;
        end
      end
    end
    if (ovf) enc_num = {4{SEG_MINUS}};
  end

  // Next-state and datapath control.
  always_comb begin
    state_d  = state_q;
    mag_d    = mag_q;
    neg_d    = neg_q;
    minov_d  = minov_q;
    bcd_d    = bcd_q;
    cnt_d    = cnt_q;
    pend_v_d = pend_v_q;
    pend_d   = pend_q;
    number_d = number_q;
    done_d   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend_v_q || load_i) begin
          mag_d   = cap_mag;
          neg_d   = cap_neg;
          minov_d = cap_minov;
          bcd_d   = 20'd0;
          cnt_d   = 5'd0;
          state_d = S_CONV;
          if (pend_v_q) begin
            // A load arriving together with a pending entry replaces it.
            pend_v_d = load_i;
            pend_d   = load_i ? value_i : pend_q;
          end
        end
      end
      S_CONV: begin
        if (cnt_q == CNT_LAST) begin
          state_d = S_ENC;
        end else begin
          // The top BCD digit never reaches 5 for IN_W <= 16, so it is only shifted.
          bcd_d = {bcd_q[18:16], bcd_adj, mag_q[IN_W-1]};
          mag_d = {mag_q[IN_W-2:0], 1'b0};
          cnt_d = cnt_q + 5'd1;
        end
      end
      S_ENC: begin
        number_d = enc_num;
        done_d   = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_q != S_IDLE && load_i) begin
      pend_v_d = 1'b1;
      pend_d   = value_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      mag_q    <= '0;
      neg_q    <= 1'b0;
      minov_q  <= 1'b0;
      bcd_q    <= 20'd0;
      cnt_q    <= 5'd0;
      pend_v_q <= 1'b0;
      pend_q   <= '0;
      number_q <= {4{SEG_BLANK}};
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mag_q    <= mag_d;
      neg_q    <= neg_d;
      minov_q  <= minov_d;
      bcd_q    <= bcd_d;
      cnt_q    <= cnt_d;
      pend_v_q <= pend_v_d;
      pend_q   <= pend_d;
      number_q <= number_d;
      done_q   <= done_d;
    end
  end

  // Busy from the first shift step until the result is registered.
  assign busy_o   = (state_q == S_CONV && cnt_q != 5'd0) || (state_q == S_ENC);
  assign done_o   = done_q;
  assign number_o = number_q;

endmodule

// File: tb/tb_temp_seg_encoder.sv
// ---------------------------------------------------------------------------
// tb_temp_seg_encoder
//   Drives three encoder instances from one load strobe: 14-bit with blanking,
//   14-bit without blanking, and 16-bit with blanking (to reach positive
//   overflow). Expected display patterns come from an arithmetic model of the
//   display rules and are queued per instance; a monitor pops them on done_o.
// ---------------------------------------------------------------------------
module tb_temp_seg_encoder;

  localparam logic [6:0] BL = 7'b1111111;
  localparam logic [6:0] MI = 7'b0111111;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [13:0] value14;
  logic [15:0] value16;
  logic        busy1, done1, busy0, done0, busy16, done16;
  logic [27:0] num1, num0, num16;

  int compared   = 0;
  int mismatched = 0;
  int dones1     = 0;
  int dones_all  = 0;

  logic [27:0] exp_q[$];
  logic [27:0] exp0_q[$];
  logic [27:0] exp16_q[$];

  temp_seg_encoder #(.IN_W(14), .LZB(1'b1)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .load_i(load), .value_i(value14),
    .busy_o(busy1), .done_o(done1), .number_o(num1));

  temp_seg_encoder #(.IN_W(14), .LZB(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .load_i(load), .value_i(value14),
    .busy_o(busy0), .done_o(done0), .number_o(num0));

  temp_seg_encoder #(.IN_W(16), .LZB(1'b1)) u_dut16 (
    .clk_i(clk), .rst_i(rst), .load_i(load), .value_i(value16),
    .busy_o(busy16), .done_o(done16), .number_o(num16));

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [27:0] obs, input logic [27:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  function automatic logic [27:0] model(input int v, input bit lzb, input int w);
    logic [6:0] seg [4];
    int m, nd, p;
    if (v > 9999 || v < -999 || v == -(1 << (w - 1))) return {MI, MI, MI, MI};
    m  = (v < 0) ? -v : v;
    nd = (m >= 1000) ? 4 : (m >= 100) ? 3 : (m >= 10) ? 2 : 1;
    p  = 1;
    for (int i = 0; i < 4; i++) begin
      if (!lzb || i < nd) seg[i] = seg_of((m / p) % 10);
      else                seg[i] = BL;
      p = p * 10;
    end
    if (v < 0) begin
      if (!lzb) seg[3]  = MI;
      else      seg[nd] = MI;
    end
    return {seg[3], seg[2], seg[1], seg[0]};
  endfunction

  function automatic int sx14(input int v);
    logic [13:0] t;
    t = v[13:0];
    return int'($signed(t));
  endfunction

  task automatic push_exp(input int v);
    exp_q.push_back(model(sx14(v), 1'b1, 14));
    exp0_q.push_back(model(sx14(v), 1'b0, 14));
    exp16_q.push_back(model(v, 1'b1, 16));
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    if (!rst) begin
      if (done1) begin
        dones1++;
        dones_all++;
        if (exp_q.size() == 0) check("unexpected_done_lzb1", {27'd0, done1}, 28'd0);
        else                   check("number_lzb1", num1, exp_q.pop_front());
      end
      if (done0) begin
        dones_all++;
        if (exp0_q.size() == 0) check("unexpected_done_lzb0", {27'd0, done0}, 28'd0);
        else                    check("number_lzb0", num0, exp0_q.pop_front());
      end
      if (done16) begin
        dones_all++;
        if (exp16_q.size() == 0) check("unexpected_done_w16", {27'd0, done16}, 28'd0);
        else                     check("number_w16", num16, exp16_q.pop_front());
      end
      if (done1 || done0) check("done_align", {27'd0, done0}, {27'd0, done1});
    end
  end

  // ---------------- driver tasks ----------------
  // Call away from the clock edge; returns 1 ns after the sampling edge.
  task automatic do_load(input int v);
    load    = 1'b1;
    value14 = v[13:0];
    value16 = v[15:0];
    @(posedge clk);
    #1;
    load = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() + exp0_q.size() + exp16_q.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    @(negedge clk);
    check("drain_timeout", 28'(exp_q.size() + exp0_q.size() + exp16_q.size()), 28'd0);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int lat, busy_cnt, d_before, v, gap;
    bit got;

    rst = 1'b1; load = 1'b0; value14 = '0; value16 = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_number", num1, 28'hFFFFFFF);
    check("reset_busy", {27'd0, busy1}, 28'd0);
    check("reset_done", {27'd0, done1}, 28'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // 1234: latency and busy length
    push_exp(1234);
    do_load(1234);
    check("busy_load_cycle", {27'd0, busy1}, 28'd0);
    lat = 0; busy_cnt = 0; got = 0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(posedge clk);
      #1;
      if (busy1) busy_cnt++;
      if (done1) begin got = 1; lat = n; end
    end
    check("latency_1234", 28'(lat), 28'd16);
    check("busy_cycles_1234", 28'(busy_cnt), 28'd15);
    check("num_1234", num1, {seg_of(1), seg_of(2), seg_of(3), seg_of(4)});
    wait_drain(60);

    // Reset mid-conversion with a pending request: no done, display blank.
    do_load(1234);
    repeat (3) @(posedge clk);
    #1;
    do_load(55);
    repeat (3) @(posedge clk);
    #1;
    d_before = dones_all;
    rst = 1'b1;
    #1;
    check("midreset_number", num1, 28'hFFFFFFF);
    check("midreset_busy", {27'd0, busy1}, 28'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (40) @(posedge clk);
    #1;
    check("midreset_no_done", 28'(dones_all - d_before), 28'd0);
    check("midreset_still_blank", num1, 28'hFFFFFFF);

    // Zero and small negative, blanked and unblanked.
    push_exp(0);
    do_load(0);
    wait_drain(60);
    check("zero_lzb1", num1, {BL, BL, BL, seg_of(0)});
    check("zero_lzb0", num0, {seg_of(0), seg_of(0), seg_of(0), seg_of(0)});
    push_exp(-7);
    do_load(-7);
    wait_drain(60);
    check("neg7_lzb1", num1, {BL, BL, MI, seg_of(7)});
    check("neg7_lzb0", num0, {MI, seg_of(0), seg_of(0), seg_of(7)});
    push_exp(42);
    do_load(42);
    wait_drain(60);
    check("pos42_lzb0", num0, {seg_of(0), seg_of(0), seg_of(4), seg_of(2)});

    // Overflow cases; 10000 is exercised on the 16-bit instance.
    d_before = dones1;
    push_exp(10000);  do_load(10000);  wait_drain(60);
    check("ovf_10000_w16", num16, {MI, MI, MI, MI});
    push_exp(-1000);  do_load(-1000);  wait_drain(60);
    check("ovf_m1000", num1, {MI, MI, MI, MI});
    push_exp(-8192);  do_load(-8192);  wait_drain(60);
    check("ovf_m8192", num1, {MI, MI, MI, MI});
    check("ovf_done_count", 28'(dones1 - d_before), 28'd3);

    // Loads while busy: last one wins, 99 is never shown.
    d_before = dones1;
    push_exp(25);
    push_exp(310);
    do_load(25);
    repeat (2) @(posedge clk);
    #1;
    do_load(99);
    repeat (2) @(posedge clk);
    #1;
    do_load(310);
    wait_drain(120);
    repeat (25) @(posedge clk);
    #1;
    check("pend_done_count", 28'(dones1 - d_before), 28'd2);
    check("pend_final", num1, {BL, seg_of(3), seg_of(1), seg_of(0)});

    // Load in the ENC cycle: back-to-back spacing.
    push_exp(123);
    push_exp(-456);
    do_load(123);
    repeat (15) @(posedge clk);
    #1;
    do_load(-456);
    check("done_in_enc_cycle", {27'd0, done1}, 28'd1);
    gap = 0; got = 0;
    for (int n = 1; n <= 40 && !got; n++) begin
      @(posedge clk);
      #1;
      if (done1) begin got = 1; gap = n; end
    end
    check("b2b_spacing", 28'(gap), 28'd17);
    wait_drain(60);

    // Randomized single conversions.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(0, 1) == 1) v = int'($urandom_range(0, 10998)) - 999;
      else                           v = int'($urandom_range(0, 16383)) - 8192;
      push_exp(v);
      do_load(v);
      wait_drain(60);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
